// File: rtl/interp_out_formatter.sv
// Rounds, shifts and saturates fast-rate interpolator samples to the DAC width,
// then buffers them in a show-ahead FIFO with valid/ready and drop/saturation stats.
module interp_out_formatter #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 12,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             in_data,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            out_data,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        sat_flag,
  output logic [15:0]                 sat_count,
  output logic                        ovf_flag,
  output logic [15:0]                 ovf_count,
  input  logic                        clr_stats
);

  localparam int AW   = $clog2(DEPTH);
  localparam int R1_W = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0]    RND     = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [15:0]      CNT_MAX = 16'hFFFF;

  logic                    v1_q, v1_d, v2_q, v2_d;
  logic signed [R1_W-1:0]  r1_q, r1_d;
  logic [OUT_W-1:0]        r2_q, r2_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0]        mem_q [DEPTH];
  logic [OUT_W-1:0]        mem_d [DEPTH];
  logic                    sat_flag_q, sat_flag_d, ovf_flag_q, ovf_flag_d;
  logic [15:0]             sat_count_q, sat_count_d, ovf_count_q, ovf_count_d;

  logic r1_oor, sat_event, fifo_full, fifo_empty, pop, push, drop;

  always_comb begin
    // Rounding add is done one bit wider than the input so it can never wrap.
    r1_d = R1_W'(($signed({in_data[IN_W-1], in_data}) + $signed(RND)) >>> SHIFT);
    v1_d = in_valid;

    r1_oor = !((&r1_q[R1_W-1:OUT_W-1]) || !(|r1_q[R1_W-1:OUT_W-1]));
    r2_d   = r1_oor ? (r1_q[R1_W-1] ? OUT_MIN : OUT_MAX) : r1_q[OUT_W-1:0];
    v2_d   = v1_q;
    sat_event = v1_q & r1_oor;

    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop  = !fifo_empty && out_ready;
    push = v2_q && (!fifo_full || pop);
    drop = v2_q && fifo_full && !pop;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = r2_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // A clear and an event in the same cycle leave the event recorded.
    sat_count_d = clr_stats ? 16'd0 : sat_count_q;
    if (sat_event && sat_count_d != CNT_MAX) sat_count_d = sat_count_d + 16'd1;
    sat_flag_d  = (clr_stats ? 1'b0 : sat_flag_q) | sat_event;

    ovf_count_d = clr_stats ? 16'd0 : ovf_count_q;
    if (drop && ovf_count_d != CNT_MAX) ovf_count_d = ovf_count_d + 16'd1;
    ovf_flag_d  = (clr_stats ? 1'b0 : ovf_flag_q) | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      r1_q        <= '0;
      r2_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_q       <= '{default: '0};
      sat_flag_q  <= 1'b0;
      ovf_flag_q  <= 1'b0;
      sat_count_q <= '0;
      ovf_count_q <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
      sat_flag_q  <= sat_flag_d;
      ovf_flag_q  <= ovf_flag_d;
      sat_count_q <= sat_count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid  = !fifo_empty;
  assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign sat_flag   = sat_flag_q;
  assign sat_count  = sat_count_q;
  assign ovf_flag   = ovf_flag_q;
  assign ovf_count  = ovf_count_q;

endmodule
